ret_addr_stack: RTL and testbench

RET_ADDR_STACK -- requirements
Module: ret_addr_stack

---
 rtl/ret_addr_stack_pkg.sv | 22 ++
 rtl/ret_addr_stack_stack_mem.sv | 24 ++
 rtl/ret_addr_stack.sv | 111 +++++++++++
 tb/tb_ret_addr_stack.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ret_addr_stack_pkg.sv
// Shared processor definitions for the return-address stack: default sizing
// and the push/pop operation encoding.
package ret_addr_stack_pkg;

  localparam int RAS_ADDR_W = 12;
  localparam int RAS_DEPTH  = 8;
  localparam int RAS_PTR_W  = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } ras_op_e;

  // {push, pop} maps straight onto the encoding; a stalled stage issues nothing.
  function automatic ras_op_e ras_decode(input logic en, input logic push,
                                         input logic pop);
    return en ? ras_op_e'({push, pop}) : OP_NONE;
  endfunction

endpackage

// File: rtl/ret_addr_stack_stack_mem.sv
// Register-file storage for the return-address stack: one synchronous write
// port and one combinational read port; contents are not reset.
module stack_mem #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [DEPTH-1:0][ADDR_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: pointer/count/sticky-error control around a
// stack_mem register file. Overflow overwrites the oldest entry.
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter int ADDR_W = RAS_ADDR_W,
  parameter int DEPTH  = RAS_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          pushAddr,
  input  logic                       pop,
  input  logic                       clrErr,
  output logic [ADDR_W-1:0]          popAddr,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   tp_q, tp_d, top_idx, waddr;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;
  logic               ovf_set, unf_set, we;
  logic [ADDR_W-1:0]  rdata;
  ras_op_e            op;

  assign op      = ras_decode(en, push, pop);
  assign top_idx = tp_q - PTR_W'(1);
  assign empty   = (count_q == '0);
  assign full    = (count_q == COUNT_W'(DEPTH));

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    we      = 1'b0;
    waddr   = tp_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        we   = 1'b1;
        tp_d = tp_q + PTR_W'(1);
        if (full) ovf_set = 1'b1;
        else      count_d = count_q + COUNT_W'(1);
      end
      OP_POP: begin
        if (empty) unf_set = 1'b1;
        else begin
          tp_d    = top_idx;
          count_d = count_q - COUNT_W'(1);
        end
      end
      OP_REPL: begin
        we = 1'b1;
        // Empty stack has no top to replace: degrade to a plain push.
        if (empty) begin
          unf_set = 1'b1;
          tp_d    = tp_q + PTR_W'(1);
          count_d = count_q + COUNT_W'(1);
        end else begin
          waddr = top_idx;
        end
      end
      default: ;
    endcase
    // Set wins over a simultaneous clear.
    ovf_d = ovf_set | (ovf_q & ~clrErr);
    unf_d = unf_set | (unf_q & ~clrErr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // A write during reset is harmless: no output reads an entry above count.
  stack_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (pushAddr),
    .raddr_i (top_idx),
    .rdata_o (rdata)
  );

  assign popAddr = empty ? '0 : rdata;
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed test of ret_addr_stack (DEPTH=8, ADDR_W=12) with hand-computed
// expectations checked by immediate assertions.
module tb_ret_addr_stack;

  logic        clk = 1'b0;
  logic        rst, en, push, pop, clrErr;
  logic [11:0] pushAddr, popAddr;
  logic        empty, full, ovf, unf;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  ret_addr_stack #(.ADDR_W(12), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .push     (push),
    .pushAddr (pushAddr),
    .pop      (pop),
    .clrErr   (clrErr),
    .popAddr  (popAddr),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; clrErr = 1'b0; en = 1'b1; rst = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_push(input logic [11:0] a);
    push = 1'b1; pushAddr = a; tick();
  endtask

  task automatic do_pop();
    pop = 1'b1; tick();
  endtask

  initial begin
    idle(); pushAddr = '0;
    rst = 1'b0; push = 1'b1; pop = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    idle();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_pop",   popAddr, 0);
    chk("rst_ovf",   ovf, 0);
    chk("rst_unf",   unf, 0);

    // basic LIFO
    do_push(12'h010); do_push(12'h020); do_push(12'h030);
    chk("lifo_count", count, 3);
    chk("lifo_top",   popAddr, 12'h030);
    do_pop(); chk("lifo_pop1", popAddr, 12'h020);
    do_pop(); chk("lifo_pop2", popAddr, 12'h010);
    do_pop(); chk("lifo_pop3", popAddr, 0);
    chk("lifo_empty", empty, 1);
    chk("lifo_cnt0",  count, 0);

    // fill, overflow, drain
    for (int i = 0; i < 8; i++) do_push(12'h100 + 12'(i));
    chk("fill_full",  full, 1);
    chk("fill_count", count, 8);
    chk("fill_noovf", ovf, 0);
    do_push(12'h108);
    chk("ovf_flag",  ovf, 1);
    chk("ovf_count", count, 8);
    chk("ovf_full",  full, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), popAddr, 12'h108 - 12'(i));
      do_pop();
    end
    chk("drain_empty", empty, 1);
    chk("drain_ovf_sticky", ovf, 1);
    clrErr = 1'b1; tick();
    chk("ovf_clr", ovf, 0);

    // underflow and clear priority
    do_pop();
    chk("unf_set",   unf, 1);
    chk("unf_count", count, 0);
    clrErr = 1'b1; tick();
    chk("unf_clr", unf, 0);
    clrErr = 1'b1; pop = 1'b1; tick();
    chk("unf_setwins", unf, 1);
    clrErr = 1'b1; tick();
    chk("unf_clr2", unf, 0);

    // push+pop on empty acts as push and flags underflow
    push = 1'b1; pop = 1'b1; pushAddr = 12'h3AA; tick();
    chk("pp_empty_cnt", count, 1);
    chk("pp_empty_top", popAddr, 12'h3AA);
    chk("pp_empty_unf", unf, 1);
    do_pop();
    clrErr = 1'b1; tick();

    // replace top
    do_push(12'h040); do_push(12'h050);
    push = 1'b1; pop = 1'b1; pushAddr = 12'h060; #1;
    chk("repl_old_top", popAddr, 12'h050);
    tick();
    chk("repl_new_top", popAddr, 12'h060);
    chk("repl_count",   count, 2);
    chk("repl_unf",     unf, 0);

    // stall holds state; clrErr still acts while stalled
    for (int i = 0; i < 4; i++) begin
      en = 1'b0; push = 1'b1; pop = 1'b1; pushAddr = 12'h555; tick();
      chk($sformatf("stall_cnt_%0d", i), count, 2);
      chk($sformatf("stall_top_%0d", i), popAddr, 12'h060);
    end
    do_pop();
    chk("stall_under", popAddr, 12'h040);
    do_push(12'h060);
    do_pop(); do_pop(); do_pop();
    chk("unf_before_stallclr", unf, 1);
    en = 1'b0; clrErr = 1'b1; tick();
    chk("stall_clr", unf, 0);

    // reset mid-operation
    for (int i = 0; i < 5; i++) do_push(12'h200 + 12'(i));
    chk("pre_rst_cnt", count, 5);
    rst = 1'b0; push = 1'b1; pushAddr = 12'h123; tick();
    chk("mid_rst_cnt",   count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_pop",   popAddr, 0);
    do_push(12'h7FF);
    chk("post_rst_top", popAddr, 12'h7FF);
    chk("post_rst_cnt", count, 1);
    do_pop();
    chk("post_rst_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
